// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB command arbiter: FSM state encoding and
// the bridge's slave address map.
package apb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Slave address map seen behind the bridge
  localparam logic [7:0] ADDR_MEM_BASE = 8'h00;
  localparam logic [7:0] ADDR_GPIO_DIR = 8'h10;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'h11;
  localparam logic [7:0] ADDR_GPIO_OUT = 8'h12;
  localparam logic [7:0] ADDR_UART_TX  = 8'h20;
  localparam logic [7:0] ADDR_UART_RX  = 8'h21;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request bit found
// searching upward from last+1, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan candidates last+1 .. last+NUM_REQ (mod NUM_REQ); first hit wins
  always_comb begin
    int  cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing the APB bridge command port among NUM_REQ
// requesters.
//
// Handshake: a requester raises req[i] with its rw/addr/wdata stable and
// holds it until it sees done[i]; gnt[i] is high while it owns the bridge.
// done[i] is a one-cycle pulse carrying rsp_rdata/rsp_err/rsp_timeout. A req
// still high after done counts as a fresh request. Toward the bridge,
// transfer is held high until pdone (or timeout) and then low for at least
// two cycles before the next command.
module apb_cmd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      transfer,
  output logic                      read_write,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      pdone,
  input  logic [DATA_W-1:0]         final_pr_data,
  input  logic                      plsverr,
  output logic [1:0]                dbg_state
);
  import apb_arb_pkg::*;

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    last, owner;
  logic                lat_rw;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [TO_W-1:0]     cnt;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                any_req;
  logic                timeout_hit;
  logic                finish;

  // Command source: the fresh pick while idle, otherwise the latched command
  logic [IDX_W-1:0]    cmd_idx;
  logic                cmd_rw;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  // Next values of the registered outputs
  logic [NUM_REQ-1:0]  gnt_d, done_d;
  logic [DATA_W-1:0]   rsp_rdata_d, wr_data_d;
  logic                rsp_err_d, rsp_timeout_d, transfer_d, read_write_d;
  logic [ADDR_W-1:0]   wr_addr_d, rd_addr_d;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .last  (last),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  assign any_req     = |req;
  assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));
  assign dbg_state   = state;

  // State register
  always_ff @(posedge pclk) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; pdone only matters in BUSY
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (any_req) state_nx = ST_BUSY;
      ST_BUSY: if (pdone || timeout_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant pointer, latched command and BUSY cycle counter
  always_ff @(posedge pclk) begin
    if (preset) begin
      last      <= LAST_RST;
      owner     <= '0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        last      <= pick_idx;
        owner     <= pick_idx;
        lat_rw    <= cmd_rw;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
      if (state == ST_BUSY) cnt <= cnt + TO_W'(1);
      else                  cnt <= '0;
    end
  end

  // Output decode from the upcoming state so every output is registered
  always_comb begin
    if (state == ST_IDLE) begin
      cmd_idx   = pick_idx;
      cmd_rw    = req_rw[pick_idx];
      cmd_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      cmd_wdata = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
    end else begin
      cmd_idx   = owner;
      cmd_rw    = lat_rw;
      cmd_addr  = lat_addr;
      cmd_wdata = lat_wdata;
    end
    finish        = (state == ST_BUSY) && (state_nx == ST_RESP);
    transfer_d    = (state_nx == ST_BUSY);
    read_write_d  = transfer_d && cmd_rw;
    rd_addr_d     = (transfer_d && cmd_rw)  ? cmd_addr  : '0;
    wr_addr_d     = (transfer_d && !cmd_rw) ? cmd_addr  : '0;
    wr_data_d     = (transfer_d && !cmd_rw) ? cmd_wdata : '0;
    gnt_d         = (state_nx != ST_IDLE) ? (NUM_REQ'(1) << cmd_idx) : '0;
    done_d        = finish ? (NUM_REQ'(1) << owner) : '0;
    rsp_rdata_d   = (finish && pdone && lat_rw) ? final_pr_data : '0;
    rsp_err_d     = finish && (pdone ? plsverr : 1'b1);
    rsp_timeout_d = finish && !pdone;
  end

  // Output registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      gnt         <= '0;
      done        <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      transfer    <= 1'b0;
      read_write  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_data     <= '0;
    end else begin
      gnt         <= gnt_d;
      done        <= done_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      transfer    <= transfer_d;
      read_write  <= read_write_d;
      wr_addr     <= wr_addr_d;
      rd_addr     <= rd_addr_d;
      wr_data     <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter. Inputs change and outputs are sampled
// on the falling edge of pclk.
module tb_apb_cmd_arbiter;
  import apb_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 11;

  logic                      pclk;
  logic                      preset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic                      transfer;
  logic                      read_write;
  logic [ADDR_W-1:0]         wr_addr;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      pdone;
  logic [DATA_W-1:0]         final_pr_data;
  logic                      plsverr;
  logic [1:0]                dbg_state;

  int checks = 0;
  int errors = 0;

  apb_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .transfer(transfer), .read_write(read_write), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .wr_data(wr_data), .pdone(pdone),
    .final_pr_data(final_pr_data), .plsverr(plsverr), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Driver tasks
  task automatic step();
    @(negedge pclk);
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
    req_rw[i] = rw;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Waits for transfer to be high; n is the number of low samples seen
  task automatic wait_xfer(input int budget, output int n);
    n = 0;
    while (transfer !== 1'b1 && n < budget) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) step();
    checks++; if (transfer !== 1'b0) begin errors++; $display("FAIL rst_transfer got=%0h exp=0", transfer); end
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt got=%b exp=000", gnt); end
    checks++; if (done !== 3'b000) begin errors++; $display("FAIL rst_done got=%b exp=000", done); end
    checks++; if ({rsp_rdata, rsp_err, rsp_timeout} !== 10'd0) begin errors++; $display("FAIL rst_rsp got=%h/%b/%b exp=0", rsp_rdata, rsp_err, rsp_timeout); end
    checks++; if ({wr_addr, rd_addr, wr_data, read_write} !== 25'd0) begin errors++; $display("FAIL rst_bridge got=%h/%h/%h/%b exp=0", wr_addr, rd_addr, wr_data, read_write); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    preset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    set_cmd(0, 1'b0, 8'h0B, 8'hAF);
    req[0] = 1'b1;
    step();
    checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL wr_transfer got=%0h exp=1", transfer); end
    checks++; if (wr_addr !== 8'h0B || wr_data !== 8'hAF) begin errors++; $display("FAIL wr_cmd got=%h/%h exp=0b/af", wr_addr, wr_data); end
    checks++; if (rd_addr !== 8'h00 || read_write !== 1'b0) begin errors++; $display("FAIL wr_rdside got=%h/%b exp=00/0", rd_addr, read_write); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt got=%b exp=001", gnt); end
    repeat (3) begin
      step();
      checks++; if (transfer !== 1'b1 || done !== 3'b000) begin errors++; $display("FAIL wr_hold got=%b/%b exp=1/000", transfer, done); end
    end
    pdone = 1'b1;
    final_pr_data = 8'h77;
    step();
    pdone = 1'b0;
    req[0] = 1'b0;
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL wr_done got=%b exp=001", done); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL wr_rsp_flags got=%b/%b exp=0/0", rsp_err, rsp_timeout); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata got=%h exp=00", rsp_rdata); end
    checks++; if (transfer !== 1'b0 || gnt !== 3'b001) begin errors++; $display("FAIL wr_resp_bus got=%b/%b exp=0/001", transfer, gnt); end
    step();
    checks++; if (done !== 3'b000 || gnt !== 3'b000) begin errors++; $display("FAIL wr_done_once got=%b/%b exp=000/000", done, gnt); end
    step();
  endtask

  task automatic test_read();
    set_cmd(1, 1'b1, ADDR_GPIO_IN, 8'h5A);
    req[1] = 1'b1;
    step();
    checks++; if (rd_addr !== 8'h11 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin errors++; $display("FAIL rd_cmd got=%h/%h/%h exp=11/00/00", rd_addr, wr_addr, wr_data); end
    checks++; if (read_write !== 1'b1 || gnt !== 3'b010) begin errors++; $display("FAIL rd_rw_gnt got=%b/%b exp=1/010", read_write, gnt); end
    step();
    pdone = 1'b1;
    final_pr_data = 8'hCD;
    step();
    pdone = 1'b0;
    req[1] = 1'b0;
    checks++; if (done !== 3'b010 || rsp_rdata !== 8'hCD) begin errors++; $display("FAIL rd_done got=%b/%h exp=010/cd", done, rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", rsp_err); end
    step();
    checks++; if (rsp_rdata !== 8'h00 || done !== 3'b000) begin errors++; $display("FAIL rd_clear got=%h/%b exp=00/000", rsp_rdata, done); end
    step();
  endtask

  task automatic test_pdone_idle();
    pdone = 1'b1;
    repeat (3) step();
    pdone = 1'b0;
    checks++; if (done !== 3'b000 || transfer !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_pdone got=%b/%b/%0d exp=000/0/0", done, transfer, dbg_state); end
    step();
  endtask

  task automatic test_contention();
    int n;
    logic [2:0] exp;
    preset = 1'b1;
    step();
    preset = 1'b0;
    set_cmd(0, 1'b0, 8'h01, 8'h10);
    set_cmd(1, 1'b0, 8'h02, 8'h20);
    set_cmd(2, 1'b0, 8'h03, 8'h30);
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_xfer(10, n);
      exp = 3'b001 << (k % 3);
      checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL cont_xfer_%0d got=%b exp=1", k, transfer); end
      checks++; if (gnt !== exp) begin errors++; $display("FAIL cont_gnt_%0d got=%b exp=%b", k, gnt, exp); end
      if (k > 0) begin
        checks++; if (n < 2) begin errors++; $display("FAIL cont_gap_%0d got=%0d exp>=2", k, n); end
      end
      pdone = 1'b1;
      step();
      pdone = 1'b0;
      if (k == 3) req = 3'b000;
      checks++; if (done !== exp) begin errors++; $display("FAIL cont_done_%0d got=%b exp=%b", k, done, exp); end
    end
    repeat (2) step();
  endtask

  task automatic test_timeout();
    int n;
    set_cmd(1, 1'b1, ADDR_UART_RX, 8'h00);
    final_pr_data = 8'h55;
    req[1] = 1'b1;
    step();
    n = 0;
    while (transfer === 1'b1 && n < TIMEOUT + 10) begin
      n++;
      step();
    end
    req[1] = 1'b0;
    checks++; if (n != TIMEOUT) begin errors++; $display("FAIL to_len got=%0d exp=%0d", n, TIMEOUT); end
    checks++; if (done !== 3'b010) begin errors++; $display("FAIL to_done got=%b exp=010", done); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL to_rsp got=%b/%b/%h exp=1/1/00", rsp_err, rsp_timeout, rsp_rdata); end
    checks++; if (dbg_state !== ST_RESP) begin errors++; $display("FAIL to_state got=%0d exp=%0d", dbg_state, ST_RESP); end
    step();
    checks++; if (rsp_timeout !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b/%b exp=0/0", rsp_timeout, rsp_err); end
    step();
  endtask

  task automatic test_slverr();
    set_cmd(2, 1'b0, ADDR_GPIO_OUT, 8'h3F);
    req[2] = 1'b1;
    step();
    pdone = 1'b1;
    plsverr = 1'b1;
    step();
    pdone = 1'b0;
    plsverr = 1'b0;
    req[2] = 1'b0;
    checks++; if (done !== 3'b100) begin errors++; $display("FAIL slv_done got=%b exp=100", done); end
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin errors++; $display("FAIL slv_rsp got=%b/%b exp=1/0", rsp_err, rsp_timeout); end
    repeat (2) step();
  endtask

  task automatic test_race();
    int c;
    set_cmd(0, 1'b1, ADDR_MEM_BASE, 8'h00);
    req[0] = 1'b1;
    step();
    c = 1;
    while (c < TIMEOUT && transfer === 1'b1) begin
      step();
      c++;
    end
    checks++; if (transfer !== 1'b1) begin errors++; $display("FAIL race_hold got=%b at=%0d exp=1", transfer, c); end
    pdone = 1'b1;
    final_pr_data = 8'h3C;
    step();
    pdone = 1'b0;
    req[0] = 1'b0;
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL race_done got=%b exp=001", done); end
    checks++; if (rsp_timeout !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 8'h3C) begin errors++; $display("FAIL race_rsp got=%b/%b/%h exp=0/0/3c", rsp_timeout, rsp_err, rsp_rdata); end
    repeat (2) step();
  endtask

  task automatic test_reset_mid_busy();
    int n;
    set_cmd(2, 1'b0, ADDR_UART_TX, 8'h41);
    set_cmd(0, 1'b0, 8'h05, 8'h99);
    req[2] = 1'b1;
    step();
    checks++; if (transfer !== 1'b1 || gnt !== 3'b100 || wr_addr !== 8'h20) begin errors++; $display("FAIL rmb_start got=%b/%b/%h exp=1/100/20", transfer, gnt, wr_addr); end
    step();
    preset = 1'b1;
    step();
    checks++; if (transfer !== 1'b0 || gnt !== 3'b000 || done !== 3'b000) begin errors++; $display("FAIL rmb_reset got=%b/%b/%b exp=0/000/000", transfer, gnt, done); end
    preset = 1'b0;
    req = 3'b101;
    step();
    checks++; if (gnt !== 3'b001 || done !== 3'b000 || wr_addr !== 8'h05) begin errors++; $display("FAIL rmb_first got=%b/%b/%h exp=001/000/05", gnt, done, wr_addr); end
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    req[0] = 1'b0;
    checks++; if (done !== 3'b001) begin errors++; $display("FAIL rmb_done0 got=%b exp=001", done); end
    wait_xfer(10, n);
    checks++; if (gnt !== 3'b100 || wr_addr !== 8'h20 || wr_data !== 8'h41) begin errors++; $display("FAIL rmb_second got=%b/%h/%h exp=100/20/41", gnt, wr_addr, wr_data); end
    pdone = 1'b1;
    step();
    pdone = 1'b0;
    req[2] = 1'b0;
    checks++; if (done !== 3'b100) begin errors++; $display("FAIL rmb_done2 got=%b exp=100", done); end
    repeat (2) step();
  endtask

  initial begin
    preset = 1'b1;
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    pdone = 1'b0;
    final_pr_data = '0;
    plsverr = 1'b0;
    step();
    test_reset();
    test_single_write();
    test_read();
    test_pdone_idle();
    test_contention();
    test_timeout();
    test_slverr();
    test_race();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
